// File: rtl/dbg_trace_pkg.sv
// Shared types and helpers for the debug trace-capture unit.
package dbg_trace_pkg;

    typedef enum logic [1:0] {
        TrigImmediate = 2'd0,
        TrigMatch     = 2'd1,
        TrigNomatch   = 2'd2,
        TrigExternal  = 2'd3
    } trig_mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPre  = 2'd1,
        StPost = 2'd2,
        StDone = 2'd3
    } cap_state_e;

    // Width of one stored entry: {timestamp, data}.
    function automatic int unsigned entry_width(input int unsigned ts_w,
                                                input int unsigned data_w);
        return ts_w + data_w;
    endfunction

endpackage

// File: rtl/dbg_trace_ram.sv
// Simple dual-port capture memory: one write port, one registered read port.
// A read colliding with a write to the same entry returns the old contents.
module dbg_trace_ram #(
    parameter  int unsigned WIDTH = 80,
    parameter  int unsigned DEPTH = 512,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port; contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read; the output register alone is reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dbg_trace_capture.sv
// Trace-capture ring buffer with channel select, trigger and post-trigger depth.
module dbg_trace_capture
    import dbg_trace_pkg::*;
#(
    parameter  int unsigned NUM_CH     = 4,
    parameter  int unsigned DATA_WIDTH = 64,
    parameter  int unsigned DEPTH      = 512,
    parameter  int unsigned TS_WIDTH   = 16,
    localparam int unsigned AW         = $clog2(DEPTH),
    localparam int unsigned CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned EW         = entry_width(TS_WIDTH, DATA_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i,
    input  logic [NUM_CH-1:0]            ch_valid_i,
    input  logic                         arm_i,
    input  logic                         abort_i,
    input  logic [CW-1:0]                ch_sel_i,
    input  logic [1:0]                   trig_mode_i,
    input  logic [DATA_WIDTH-1:0]        trig_value_i,
    input  logic [DATA_WIDTH-1:0]        trig_mask_i,
    input  logic                         trig_ext_i,
    input  logic [AW:0]                  post_count_i,
    input  logic                         rd_en_i,
    input  logic [AW-1:0]                rd_addr_i,
    output logic [EW-1:0]                rd_data_o,
    output logic                         rd_valid_o,
    output logic [1:0]                   state_o,
    output logic                         triggered_o,
    output logic                         wrapped_o,
    output logic [AW:0]                  sample_count_o,
    output logic [AW-1:0]                trig_index_o
);

    cap_state_e            state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         trig_ptr_q, trig_ptr_d;
    logic [AW-1:0]         remain_q, remain_d;
    logic [AW:0]           count_q, count_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d, ts_inc;
    logic                  trig_q, trig_d;
    logic                  wrap_q, wrap_d;
    logic [CW-1:0]         sel_q, sel_d;
    trig_mode_e            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [AW:0]           post_q, post_d;
    logic                  rd_valid_q;

    logic [DATA_WIDTH-1:0] sample;
    logic                  accept;
    logic                  match;
    logic                  trig_hit;
    logic [AW-1:0]         oldest;

    assign sample = ch_data_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
    assign ts_inc = (ts_q == '1) ? ts_q : ts_q + 1'b1;
    // arm/abort cycles never write; reset cycles never write either.
    assign accept = rst_n && ch_valid_i[sel_q] && !arm_i && !abort_i &&
                    (state_q == StPre || state_q == StPost);
    assign match  = ((sample ^ value_q) & mask_q) == '0;

    // Trigger qualifier for the selected sample.
    always_comb begin
        trig_hit = 1'b0;
        unique case (mode_q)
            TrigImmediate: trig_hit = 1'b1;
            TrigMatch:     trig_hit = match;
            TrigNomatch:   trig_hit = !match;
            TrigExternal:  trig_hit = trig_ext_i;
            default:       trig_hit = 1'b0;
        endcase
    end

    // Next-state logic: abort beats arm, arm beats sample acceptance.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        trig_ptr_d = trig_ptr_q;
        remain_d   = remain_q;
        count_d    = count_q;
        ts_d       = (state_q == StIdle) ? ts_q : ts_inc;
        trig_d     = trig_q;
        wrap_d     = wrap_q;
        sel_d      = sel_q;
        mode_d     = mode_q;
        value_d    = value_q;
        mask_d     = mask_q;
        post_d     = post_q;
        if (abort_i) begin
            state_d = StIdle;
        end else if (arm_i) begin
            state_d    = StPre;
            sel_d      = CW'(32'(ch_sel_i) % NUM_CH);
            mode_d     = trig_mode_e'(trig_mode_i);
            value_d    = trig_value_i;
            mask_d     = trig_mask_i;
            post_d     = post_count_i;
            wr_ptr_d   = '0;
            trig_ptr_d = '0;
            count_d    = '0;
            ts_d       = '0;
            trig_d     = 1'b0;
            wrap_d     = 1'b0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == '1) begin
                wrap_d = 1'b1;
            end
            if (count_q != (AW+1)'(DEPTH)) begin
                count_d = count_q + 1'b1;
            end
            if (state_q == StPre) begin
                if (trig_hit) begin
                    trig_ptr_d = wr_ptr_q;
                    trig_d     = 1'b1;
                    remain_d   = (post_q > (AW+1)'(DEPTH - 1)) ? AW'(DEPTH - 1) : post_q[AW-1:0];
                    state_d    = (post_q == '0) ? StDone : StPost;
                end
            end else begin
                remain_d = remain_q - 1'b1;
                if (remain_q == AW'(1)) begin
                    state_d = StDone;
                end
            end
        end
    end

    // State and configuration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            trig_ptr_q <= '0;
            remain_q   <= '0;
            count_q    <= '0;
            ts_q       <= '0;
            trig_q     <= 1'b0;
            wrap_q     <= 1'b0;
            sel_q      <= '0;
            mode_q     <= TrigImmediate;
            value_q    <= '0;
            mask_q     <= '0;
            post_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            trig_ptr_q <= trig_ptr_d;
            remain_q   <= remain_d;
            count_q    <= count_d;
            ts_q       <= ts_d;
            trig_q     <= trig_d;
            wrap_q     <= wrap_d;
            sel_q      <= sel_d;
            mode_q     <= mode_d;
            value_q    <= value_d;
            mask_q     <= mask_d;
            post_q     <= post_d;
            rd_valid_q <= rd_en_i;
        end
    end

    // Logical indices are relative to the oldest entry still in the ring.
    assign oldest = wrap_q ? wr_ptr_q : '0;

    dbg_trace_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (accept),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({ts_inc, sample}),
        .rd_en_i   (rd_en_i),
        .rd_addr_i (oldest + rd_addr_i),
        .rd_data_o (rd_data_o)
    );

    assign rd_valid_o     = rd_valid_q;
    assign state_o        = state_q;
    assign triggered_o    = trig_q;
    assign wrapped_o      = wrap_q;
    assign sample_count_o = count_q;
    assign trig_index_o   = trig_ptr_q - oldest;

endmodule

// File: tb/tb_dbg_trace_capture.sv
// Directed self-checking bench for dbg_trace_capture (DEPTH=16, 4 x 16-bit channels).
module tb_dbg_trace_capture;
    import dbg_trace_pkg::*;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned TS_WIDTH   = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] ch_data_i;
    logic [3:0]  ch_valid_i;
    logic        arm_i;
    logic        abort_i;
    logic [1:0]  ch_sel_i;
    logic [1:0]  trig_mode_i;
    logic [15:0] trig_value_i;
    logic [15:0] trig_mask_i;
    logic        trig_ext_i;
    logic [4:0]  post_count_i;
    logic        rd_en_i;
    logic [3:0]  rd_addr_i;
    logic [23:0] rd_data_o;
    logic        rd_valid_o;
    logic [1:0]  state_o;
    logic        triggered_o;
    logic        wrapped_o;
    logic [4:0]  sample_count_o;
    logic [3:0]  trig_index_o;

    int checks   = 0;
    int failures = 0;
    logic [23:0] rd;

    always #5 clk = ~clk;

    dbg_trace_capture #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .TS_WIDTH   (TS_WIDTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ch_data_i      (ch_data_i),
        .ch_valid_i     (ch_valid_i),
        .arm_i          (arm_i),
        .abort_i        (abort_i),
        .ch_sel_i       (ch_sel_i),
        .trig_mode_i    (trig_mode_i),
        .trig_value_i   (trig_value_i),
        .trig_mask_i    (trig_mask_i),
        .trig_ext_i     (trig_ext_i),
        .post_count_i   (post_count_i),
        .rd_en_i        (rd_en_i),
        .rd_addr_i      (rd_addr_i),
        .rd_data_o      (rd_data_o),
        .rd_valid_o     (rd_valid_o),
        .state_o        (state_o),
        .triggered_o    (triggered_o),
        .wrapped_o      (wrapped_o),
        .sample_count_o (sample_count_o),
        .trig_index_o   (trig_index_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Selected channel carries d/v; every other channel is always valid with junk.
    task automatic smp(input int ch, input logic [15:0] d, input logic v, input logic ext);
        ch_data_i              = {4{16'hBEEF}};
        ch_data_i[ch*16 +: 16] = d;
        ch_valid_i             = 4'hF;
        ch_valid_i[ch]         = v;
        trig_ext_i             = ext;
        step();
    endtask

    // Config is scrambled after the arm edge to prove it was latched.
    task automatic arm(input int ch, input logic [1:0] mode, input logic [15:0] val,
                       input logic [15:0] mask, input logic [4:0] post);
        ch_valid_i   = 4'h0;
        arm_i        = 1'b1;
        ch_sel_i     = ch[1:0];
        trig_mode_i  = mode;
        trig_value_i = val;
        trig_mask_i  = mask;
        post_count_i = post;
        step();
        arm_i        = 1'b0;
        ch_sel_i     = ~ch[1:0];
        trig_mode_i  = ~mode;
        trig_value_i = ~val;
        trig_mask_i  = ~mask;
        post_count_i = ~post;
    endtask

    task automatic rdidx(input logic [3:0] idx, output logic [23:0] data);
        rd_en_i   = 1'b1;
        rd_addr_i = idx;
        step();
        rd_en_i   = 1'b0;
        data      = rd_data_o;
        chk("rd_valid", 64'(rd_valid_o), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; ch_data_i = '0; ch_valid_i = '0; arm_i = 1'b0; abort_i = 1'b0;
        ch_sel_i = '0; trig_mode_i = '0; trig_value_i = '0; trig_mask_i = '0;
        trig_ext_i = 1'b0; post_count_i = '0; rd_en_i = 1'b0; rd_addr_i = '0;
        step();
        step();
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_count", 64'(sample_count_o), 64'd0);
        chk("rst_trig", 64'(triggered_o), 64'd0);
        chk("rst_rdvalid", 64'(rd_valid_o), 64'd0);
        chk("rst_rddata", 64'(rd_data_o), 64'd0);
        rst_n = 1'b1;
        step();

        // Basic capture: IMMEDIATE, post=3, ch2, data=i, ts=i+1.
        arm(2, TrigImmediate, 16'h0, 16'h0, 5'd3);
        chk("t1_pre", 64'(state_o), 64'd1);
        smp(2, 16'd0, 1'b1, 1'b0);
        chk("t1_post", 64'(state_o), 64'd2);
        for (int i = 1; i < 4; i++) smp(2, 16'(i), 1'b1, 1'b0);
        chk("t1_done", 64'(state_o), 64'd3);
        smp(2, 16'd9, 1'b1, 1'b0);
        smp(2, 16'd9, 1'b1, 1'b0);
        chk("t1_count", 64'(sample_count_o), 64'd4);
        chk("t1_tidx", 64'(trig_index_o), 64'd0);
        chk("t1_trig", 64'(triggered_o), 64'd1);
        chk("t1_wrap", 64'(wrapped_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            rdidx(4'(i), rd);
            chk("t1_rd", 64'(rd), 64'({8'(i + 1), 16'(i)}));
        end
        step();
        chk("rd_pulse", 64'(rd_valid_o), 64'd0);

        // Ring wrap: MATCH 0x40/0xFF, post=5 over 0x00..0x4F; ring holds 0x36..0x45.
        arm(0, TrigMatch, 16'h0040, 16'h00FF, 5'd5);
        for (int i = 0; i < 'h50; i++) smp(0, 16'(i), 1'b1, 1'b0);
        chk("t2_state", 64'(state_o), 64'd3);
        chk("t2_wrap", 64'(wrapped_o), 64'd1);
        chk("t2_count", 64'(sample_count_o), 64'd16);
        chk("t2_tidx", 64'(trig_index_o), 64'd10);
        rdidx(4'd0, rd);
        chk("t2_idx0", 64'(rd[15:0]), 64'h36);
        rdidx(4'd10, rd);
        chk("t2_idx10", 64'(rd[15:0]), 64'h40);
        rdidx(4'd15, rd);
        chk("t2_idx15", 64'(rd[15:0]), 64'h45);

        // Post clamp: post=20 stops after DEPTH samples total.
        arm(3, TrigImmediate, 16'h0, 16'h0, 5'd20);
        for (int i = 0; i < 15; i++) smp(3, 16'(16'h100 + i), 1'b1, 1'b0);
        chk("t3_post", 64'(state_o), 64'd2);
        smp(3, 16'h10F, 1'b1, 1'b0);
        chk("t3_done", 64'(state_o), 64'd3);
        for (int i = 16; i < 20; i++) smp(3, 16'(16'h100 + i), 1'b1, 1'b0);
        chk("t3_count", 64'(sample_count_o), 64'd16);
        chk("t3_wrap", 64'(wrapped_o), 64'd1);
        chk("t3_tidx", 64'(trig_index_o), 64'd0);
        rdidx(4'd15, rd);
        chk("t3_idx15", 64'(rd), 64'({8'd16, 16'h10F}));

        // Arm in DONE clears status; post=0 ends on the trigger sample.
        arm(1, TrigMatch, 16'h0005, 16'h000F, 5'd0);
        chk("t3b_state", 64'(state_o), 64'd1);
        chk("t3b_trig", 64'(triggered_o), 64'd0);
        chk("t3b_wrap", 64'(wrapped_o), 64'd0);
        chk("t3b_count", 64'(sample_count_o), 64'd0);
        for (int i = 0; i < 5; i++) smp(1, 16'(16'h20 + i), 1'b1, 1'b0);
        chk("t3b_pre", 64'(state_o), 64'd1);
        smp(1, 16'h25, 1'b1, 1'b0);
        chk("t3b_done", 64'(state_o), 64'd3);
        smp(1, 16'h26, 1'b1, 1'b0);
        chk("t3b_count6", 64'(sample_count_o), 64'd6);
        chk("t3b_tidx", 64'(trig_index_o), 64'd5);
        rdidx(4'd5, rd);
        chk("t3b_last", 64'(rd), 64'({8'd6, 16'h25}));

        // Sparse valid on ch1, EXTERNAL trigger, post=2.
        arm(1, TrigExternal, 16'h0, 16'h0, 5'd2);
        smp(1, 16'h0, 1'b0, 1'b0);
        smp(1, 16'h0, 1'b0, 1'b1);
        chk("t4_ext_novalid", 64'(triggered_o), 64'd0);
        smp(1, 16'hA0, 1'b1, 1'b0);
        chk("t4_pre", 64'(state_o), 64'd1);
        smp(1, 16'h0, 1'b0, 1'b0);
        smp(1, 16'h0, 1'b0, 1'b0);
        smp(1, 16'hA1, 1'b1, 1'b1);
        chk("t4_trig", 64'(triggered_o), 64'd1);
        chk("t4_posts", 64'(state_o), 64'd2);
        chk("t4_tidx", 64'(trig_index_o), 64'd1);
        smp(1, 16'h0, 1'b0, 1'b0);
        smp(1, 16'h0, 1'b0, 1'b0);
        smp(1, 16'hA2, 1'b1, 1'b0);
        smp(1, 16'h0, 1'b0, 1'b0);
        smp(1, 16'h0, 1'b0, 1'b0);
        smp(1, 16'hA3, 1'b1, 1'b0);
        chk("t4_done", 64'(state_o), 64'd3);
        chk("t4_count", 64'(sample_count_o), 64'd4);
        rdidx(4'd0, rd);
        chk("t4_idx0", 64'(rd), 64'({8'd3, 16'hA0}));
        rdidx(4'd1, rd);
        chk("t4_idx1", 64'(rd), 64'({8'd6, 16'hA1}));
        rdidx(4'd3, rd);
        chk("t4_idx3", 64'(rd), 64'({8'd12, 16'hA3}));

        // Abort mid-POST: the sample present in the abort cycle is not stored.
        arm(0, TrigImmediate, 16'h0, 16'h0, 5'd8);
        for (int i = 0; i < 3; i++) smp(0, 16'(16'hC0 + i), 1'b1, 1'b0);
        chk("t5_post", 64'(state_o), 64'd2);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("t5_idle", 64'(state_o), 64'd0);
        chk("t5_trig_kept", 64'(triggered_o), 64'd1);
        smp(0, 16'hC4, 1'b1, 1'b0);
        smp(0, 16'hC5, 1'b1, 1'b0);
        chk("t5_count", 64'(sample_count_o), 64'd3);
        rdidx(4'd2, rd);
        chk("t5_idx2", 64'(rd), 64'({8'd3, 16'hC2}));
        rdidx(4'd3, rd);
        chk("t5_idx3_stale", 64'(rd), 64'({8'd12, 16'hA3}));
        arm(0, TrigImmediate, 16'h0, 16'h0, 5'd4);
        arm_i   = 1'b1;
        abort_i = 1'b1;
        step();
        arm_i   = 1'b0;
        abort_i = 1'b0;
        chk("t5_arm_abort", 64'(state_o), 64'd0);

        // Reset mid-POST: outputs clear, later samples are not captured.
        arm(2, TrigImmediate, 16'h0, 16'h0, 5'd6);
        for (int i = 0; i < 3; i++) smp(2, 16'(16'hD0 + i), 1'b1, 1'b0);
        chk("t6_post", 64'(state_o), 64'd2);
        rdidx(4'd2, rd);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_state", 64'(state_o), 64'd0);
        chk("t6_trig", 64'(triggered_o), 64'd0);
        chk("t6_wrap", 64'(wrapped_o), 64'd0);
        chk("t6_count", 64'(sample_count_o), 64'd0);
        chk("t6_tidx", 64'(trig_index_o), 64'd0);
        chk("t6_rdvalid", 64'(rd_valid_o), 64'd0);
        chk("t6_rddata", 64'(rd_data_o), 64'd0);
        for (int i = 0; i < 3; i++) smp(2, 16'(16'hE0 + i), 1'b1, 1'b0);
        chk("t6_count_after", 64'(sample_count_o), 64'd0);
        chk("t6_state_after", 64'(state_o), 64'd0);
        rdidx(4'd0, rd);
        chk("t6_idx0", 64'(rd), 64'({8'd1, 16'hD0}));
        rdidx(4'd1, rd);
        chk("t6_idx1", 64'(rd), 64'({8'd2, 16'hD1}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
